// File: rtl/bus_pkg.sv
// Shared definitions for the serial system bus: field widths and the slave endpoint state encoding.
package bus_pkg;

    localparam int BUS_ADDR_W = 16;
    localparam int BUS_DEV_W  = 6;
    localparam int BUS_DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RX_DEV  = 3'd1,
        S_RX_ADDR = 3'd2,
        S_RX_DATA = 3'd3,
        S_MEM_WR  = 3'd4,
        S_RD_REQ  = 3'd5,
        S_RD_WAIT = 3'd6,
        S_TX_DATA = 3'd7
    } slave_state_e;

endpackage

// File: rtl/slave_port_if.sv
// Serial bus signals between a master port and a slave port.
interface slave_port_if;

    logic mode;
    logic wr_bus;
    logic master_valid;
    logic slave_ready;
    logic ack;
    logic rd_bus;
    logic slave_valid;
    logic master_ready;
    logic split;

    modport master (
        output mode, wr_bus, master_valid, master_ready,
        input  slave_ready, ack, rd_bus, slave_valid, split
    );

    modport slave (
        input  mode, wr_bus, master_valid, master_ready,
        output slave_ready, ack, rd_bus, slave_valid, split
    );

endinterface

// File: rtl/slave_port.sv
// Serial bus slave endpoint: deserialises address/data, does one byte access on local memory,
// serialises read data back. Define SLAVE_SPLIT_EN to raise split while a memory read is pending.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for address bit 15, latches direction
// S_RX_DEV  | receiving address bits 14..10, device compare on bit 10
// S_RX_ADDR | receiving local address bits 9..0
// S_RX_DATA | receiving 8 write-data bits
// S_MEM_WR  | one-cycle memory write strobe
// S_RD_REQ  | one-cycle memory read strobe
// S_RD_WAIT | waiting for memory read data
// S_TX_DATA | shifting read byte out, MSB first
module slave_port
    import bus_pkg::*;
#(
    parameter logic [BUS_DEV_W-1:0] DEV_ID   = 6'd0,
    parameter int                   LOCAL_AW = 10
) (
    input  logic                  clk,
    input  logic                  rstn,
    slave_port_if.slave           bus,
    output logic [LOCAL_AW-1:0]   mem_addr,
    output logic [BUS_DATA_W-1:0] mem_wr_data,
    output logic                  mem_wr_en,
    output logic                  mem_rd_en,
    input  logic [BUS_DATA_W-1:0] mem_rd_data,
    input  logic                  mem_rd_valid
);

    slave_state_e          state, state_d;
    logic [3:0]            cnt, cnt_d;
    logic [LOCAL_AW-1:0]   addr_q, addr_d;
    logic [BUS_DATA_W-1:0] wdata_q, wdata_d;
    logic [BUS_DATA_W-1:0] tx_q, tx_d;
    logic                  mode_q, mode_d;
    logic                  dev_hit;

    // Device bits are still in the low end of the address shifter when bit 10 arrives.
    assign dev_hit = ({addr_q[BUS_DEV_W-2:0], bus.wr_bus} == DEV_ID);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= S_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            tx_q    <= '0;
            mode_q  <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tx_q    <= tx_d;
            mode_q  <= mode_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        tx_d    = tx_q;
        mode_d  = mode_q;
        bus.ack = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.master_valid) begin
                    addr_d  = {addr_q[LOCAL_AW-2:0], bus.wr_bus};
                    mode_d  = bus.mode;
                    cnt_d   = 4'd1;
                    state_d = S_RX_DEV;
                end
            end
            S_RX_DEV: begin
                if (!bus.master_valid) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    addr_d = {addr_q[LOCAL_AW-2:0], bus.wr_bus};
                    cnt_d  = cnt + 4'd1;
                    if (cnt == 4'd5) begin
                        bus.ack = dev_hit;
                        if (dev_hit) begin
                            state_d = S_RX_ADDR;
                        end else begin
                            cnt_d   = '0;
                            state_d = S_IDLE;
                        end
                    end
                end
            end
            S_RX_ADDR: begin
                if (!bus.master_valid) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    // count wraps 15 -> 0 here, ready for the data phase
                    addr_d = {addr_q[LOCAL_AW-2:0], bus.wr_bus};
                    cnt_d  = cnt + 4'd1;
                    if (cnt == 4'd15) state_d = mode_q ? S_RX_DATA : S_RD_REQ;
                end
            end
            S_RX_DATA: begin
                if (!bus.master_valid) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    wdata_d = {wdata_q[BUS_DATA_W-2:0], bus.wr_bus};
                    cnt_d   = cnt + 4'd1;
                    if (cnt == 4'd7) state_d = S_MEM_WR;
                end
            end
            S_MEM_WR: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            S_RD_REQ, S_RD_WAIT: begin
                if (mem_rd_valid) begin
                    tx_d    = mem_rd_data;
                    cnt_d   = '0;
                    state_d = S_TX_DATA;
                end else begin
                    state_d = S_RD_WAIT;
                end
            end
            S_TX_DATA: begin
                if (bus.master_ready) begin
                    tx_d  = {tx_q[BUS_DATA_W-2:0], 1'b0};
                    cnt_d = cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.slave_ready = (state == S_IDLE) || (state == S_RX_DEV) ||
                             (state == S_RX_ADDR) || (state == S_RX_DATA);
    assign bus.slave_valid = (state == S_TX_DATA);
    assign bus.rd_bus      = (state == S_TX_DATA) && tx_q[BUS_DATA_W-1];
    assign mem_wr_en       = (state == S_MEM_WR);
    assign mem_rd_en       = (state == S_RD_REQ);
    assign mem_addr        = addr_q;
    assign mem_wr_data     = wdata_q;

`ifdef SLAVE_SPLIT_EN
    assign bus.split = (state == S_RD_REQ) || (state == S_RD_WAIT);
`else
    assign bus.split = 1'b0;
`endif

endmodule

// File: tb/tb_slave_port.sv
// Directed bench for slave_port with DEV_ID 6'h05: writes, reads, device miss, abort and reset.
module tb_slave_port;
    import bus_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    slave_port_if bus_if();

    logic [9:0] mem_addr;
    logic [7:0] mem_wr_data;
    logic       mem_wr_en;
    logic       mem_rd_en;
    logic [7:0] mem_rd_data;
    logic       mem_rd_valid;

    slave_port #(.DEV_ID(6'h05), .LOCAL_AW(10)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .bus          (bus_if.slave),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_wr_en    (mem_wr_en),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_data  (mem_rd_data),
        .mem_rd_valid (mem_rd_valid)
    );

`ifdef SLAVE_SPLIT_EN
    localparam logic SPLIT_ON = 1'b1;
`else
    localparam logic SPLIT_ON = 1'b0;
`endif

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    int wr_pulses = 0;
    int rd_pulses = 0;

    always @(posedge clk) begin
        if (mem_wr_en) wr_pulses++;
        if (mem_rd_en) rd_pulses++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends nbits of val MSB first; checks ack while bit index ack_at is on the bus.
    task automatic send_bits(input logic [15:0] val, input int nbits, input logic m,
                             input logic exp_ack, input int ack_at);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus_if.mode         = m;
            bus_if.wr_bus       = val[i];
            bus_if.master_valid = 1'b1;
            if (i == ack_at) begin
                #1;
                chk("ack", bus_if.ack, exp_ack);
            end
            tick();
        end
        bus_if.master_valid = 1'b0;
    endtask

    task automatic deliver(input logic [7:0] exp, input int hold_at);
        bus_if.master_ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            if (i == hold_at) begin
                bus_if.master_ready = 1'b0;
                repeat (2) begin
                    chk("rd_hold", bus_if.rd_bus, exp[i]);
                    tick();
                end
                bus_if.master_ready = 1'b1;
            end
            chk("rd_valid", bus_if.slave_valid, 1);
            chk("rd_bit", bus_if.rd_bus, exp[i]);
            tick();
        end
        bus_if.master_ready = 1'b0;
        chk("rd_done_valid", bus_if.slave_valid, 0);
        chk("rd_done_state", dut.state, S_IDLE);
    endtask

    task automatic chk_reset_outputs(input string pfx);
        chk({pfx, "_slave_ready"}, bus_if.slave_ready, 1);
        chk({pfx, "_ack"}, bus_if.ack, 0);
        chk({pfx, "_slave_valid"}, bus_if.slave_valid, 0);
        chk({pfx, "_rd_bus"}, bus_if.rd_bus, 0);
        chk({pfx, "_split"}, bus_if.split, 0);
        chk({pfx, "_mem_wr_en"}, mem_wr_en, 0);
        chk({pfx, "_mem_rd_en"}, mem_rd_en, 0);
        chk({pfx, "_mem_addr"}, mem_addr, 0);
        chk({pfx, "_mem_wr_data"}, mem_wr_data, 0);
    endtask

    initial begin
        bus_if.mode         = 1'b0;
        bus_if.wr_bus       = 1'b0;
        bus_if.master_valid = 1'b0;
        bus_if.master_ready = 1'b0;
        mem_rd_data         = 8'h00;
        mem_rd_valid        = 1'b0;

        // reset
        tick();
        tick();
        chk_reset_outputs("rst");
        rstn = 1'b1;
        tick();

        // write 0xC6 to 16'h17A3
        send_bits(16'h17A3, 16, 1'b1, 1'b1, 10);
        send_bits(16'h00C6, 8, 1'b1, 1'b0, -1);
        chk("wr_en", mem_wr_en, 1);
        chk("wr_addr", mem_addr, 10'h3A3);
        chk("wr_data", mem_wr_data, 8'hC6);
        chk("wr_ready", bus_if.slave_ready, 0);
        tick();
        chk("wr_en_off", mem_wr_en, 0);
        chk("wr_pulses1", wr_pulses, 1);

        // read 16'h1402, data after 3 cycles, stall mid-byte
        send_bits(16'h1402, 16, 1'b0, 1'b1, 10);
        chk("rd_en", mem_rd_en, 1);
        chk("rd_addr", mem_addr, 10'h002);
        chk("rd_ready", bus_if.slave_ready, 0);
        chk("rd_split_req", bus_if.split, SPLIT_ON);
        tick();
        chk("rd_en_off", mem_rd_en, 0);
        chk("rd_wait_valid", bus_if.slave_valid, 0);
        tick();
        tick();
        mem_rd_data  = 8'h5A;
        mem_rd_valid = 1'b1;
        tick();
        mem_rd_valid = 1'b0;
        chk("rd_pulses1", rd_pulses, 1);
        chk("rd_split_tx", bus_if.split, 0);
        deliver(8'h5A, 3);

        // read 16'h14FF with 10-cycle memory latency
        send_bits(16'h14FF, 16, 1'b0, 1'b1, 10);
        for (int c = 0; c < 10; c++) begin
            chk("split_pend", bus_if.split, SPLIT_ON);
            chk("split_valid_low", bus_if.slave_valid, 0);
            tick();
        end
        mem_rd_data  = 8'h96;
        mem_rd_valid = 1'b1;
        chk("split_at_valid", bus_if.split, SPLIT_ON);
        tick();
        mem_rd_valid = 1'b0;
        chk("split_released", bus_if.split, 0);
        deliver(8'h96, -1);

        // read data returned in the strobe cycle
        send_bits(16'h1401, 16, 1'b0, 1'b1, 10);
        mem_rd_data  = 8'hA5;
        mem_rd_valid = 1'b1;
        chk("early_rd_en", mem_rd_en, 1);
        tick();
        mem_rd_valid = 1'b0;
        deliver(8'hA5, -1);
        chk("rd_pulses3", rd_pulses, 3);

        // device miss: prefix 6'h09
        send_bits(16'h0009, 6, 1'b1, 1'b0, 0);
        chk("miss_idle", dut.state, S_IDLE);
        repeat (3) tick();
        chk("miss_wr_pulses", wr_pulses, 1);
        chk("miss_rd_pulses", rd_pulses, 3);

        // abort after 9 address bits, then a full write
        send_bits(16'h002F, 9, 1'b1, 1'b1, 3);
        tick();
        chk("abort_idle", dut.state, S_IDLE);
        send_bits(16'h1655, 16, 1'b1, 1'b1, 10);
        send_bits(16'h003C, 8, 1'b1, 1'b0, -1);
        chk("wr2_en", mem_wr_en, 1);
        chk("wr2_addr", mem_addr, 10'h255);
        chk("wr2_data", mem_wr_data, 8'h3C);
        tick();
        chk("wr_pulses2", wr_pulses, 2);

        // reset after 4 data bits with the master still driving
        send_bits(16'h17A3, 16, 1'b1, 1'b1, 10);
        send_bits(16'h000C, 4, 1'b1, 1'b0, -1);
        bus_if.master_valid = 1'b1;
        rstn = 1'b0;
        tick();
        chk_reset_outputs("midrst");
        rstn = 1'b1;
        bus_if.master_valid = 1'b0;
        repeat (4) tick();
        chk("midrst_wr_pulses", wr_pulses, 2);
        chk("midrst_idle", dut.state, S_IDLE);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/slave_port.md
# slave_port

Slave-side endpoint of the serial system bus. It deserialises the address and write data sent by a master port, and returns `ack` when the address selects this device. It performs a single-byte write or read on a local memory interface and serialises read data back to the master. It sits between the bus interconnect and one slave memory, and optionally uses split transactions while memory reads are pending.

## Interface
- `DEV_ID`, default 6'd0: device select; compared against address bits [15:10].
- `LOCAL_AW`, default 10: local memory address width; equals 16 minus the 6 device bits, and no other value is legal.
- `clk`  in  1  bus clock.
- `rstn`  in  1  reset, synchronous, active-low.
- `mode`  in  1  transfer direction from master: 1 = write, 0 = read.
- `wr_bus`  in  1  serial address/write-data bit, MSB first.
- `master_valid`  in  1  `wr_bus` bit is valid.
- `slave_ready`  out  1  slave accepts a `wr_bus` bit this cycle.
- `ack`  out  1  device-select acknowledge.
- `rd_bus`  out  1  serial read-data bit, MSB first.
- `slave_valid`  out  1  `rd_bus` bit is valid.
- `master_ready`  in  1  master accepts an `rd_bus` bit this cycle.
- `split`  out  1  read pending; master releases the bus.
- `mem_addr`  out  10  local address.
- `mem_wr_data`  out  8  write data.
- `mem_wr_en`  out  1  one-cycle write strobe.
- `mem_rd_en`  out  1  one-cycle read strobe.
- `mem_rd_data`  in  8  read data.
- `mem_rd_valid`  in  1  `mem_rd_data` valid; arrives 1 or more cycles after `mem_rd_en`.

## Operation
- A bit is accepted when `master_valid & slave_ready`. A read bit is delivered when `slave_valid & master_ready`.
- States: `IDLE`, `RX_DEV`, `RX_ADDR`, `RX_DATA`, `MEM_WR`, `RD_REQ`, `RD_WAIT`, `TX_DATA`.
- `IDLE`: `slave_ready`=1. On an accepted bit: capture it as address[15], latch `mode`, set bit count to 1, go to `RX_DEV`.
- `RX_DEV`: `slave_ready`=1. Accepts address bits 14..10. On the bit accepted at count==5:
  - `ack` is combinationally 1 iff {captured[4:0], `wr_bus`} == `DEV_ID`.
  - Match: go to `RX_ADDR`.
  - No match: go to `IDLE`, with `ack`=0.
- `RX_ADDR`: `slave_ready`=1. Accepts bits 9..0. After the 16th address bit (count==15):
  - `mode`=1: go to `RX_DATA`.
  - `mode`=0: go to `RD_REQ`.
- `RX_DATA`: `slave_ready`=1. After 8 data bits, go to `MEM_WR`.
- `MEM_WR`: `slave_ready`=0, `mem_wr_en`=1 for one cycle with `mem_addr`/`mem_wr_data` stable, then `IDLE`.
- `RD_REQ`: `mem_rd_en`=1 for one cycle, then `RD_WAIT`.
- `RD_WAIT`: on `mem_rd_valid`, load the shift register with `mem_rd_data` and go to `TX_DATA`. `mem_rd_valid` arriving in the `RD_REQ` cycle is also captured.
- `TX_DATA`: `slave_valid`=1, `rd_bus`=shift[7].
  - On `master_ready`: shift left and count.
  - After the 8th delivered bit, go to `IDLE`.
  - With `master_ready` low, `rd_bus` holds.
- Abort: `master_valid`=0 in `RX_DEV`, `RX_ADDR` or `RX_DATA` returns to `IDLE` with no memory access. This covers a master timeout or a deselected master.
- Bit counter: 4 bits. It is cleared on every return to `IDLE` and wraps 15→0 between the address and data phases.
- `slave_ready`=0 in `MEM_WR`, `RD_REQ`, `RD_WAIT` and `TX_DATA`.

## Timing
- Reset: state `IDLE`. Outputs on reset: `slave_ready`=1, `ack`=0, `slave_valid`=0, `rd_bus`=0, `split`=0, `mem_wr_en`=0, `mem_rd_en`=0, `mem_addr`=0, `mem_wr_data`=0.
- Reset mid-transfer discards the transaction; no strobe is issued afterwards.
- `ack` is combinational and valid only in the 6th address-bit cycle.
- Write latency: `mem_wr_en` asserts the cycle after the 8th data bit is accepted.
- Read latency: `mem_rd_en` asserts the cycle after the 16th address bit. `slave_valid` asserts the cycle after `mem_rd_valid`.
- All outputs except `ack` are Moore (registered state/data).

## Configuration
- Macro `SLAVE_SPLIT_EN`.
- Defined: `split`=1 in `RD_REQ` and `RD_WAIT`, deasserting in the cycle `TX_DATA` is entered.
- Undefined: `split` is tied to 0. The master waits in its read state while `slave_valid`=0.

## Structure
- Shared package `bus_pkg`:
  - Constants: `BUS_ADDR_W`=16, `BUS_DEV_W`=6, `BUS_DATA_W`=8.
  - Typedef: slave state enum.
- No sub-module. The shift register and counter stay inline.

## Test plan
- Write, `DEV_ID`=6'h05, address 16'h17A3, data 8'hC6:
  - `ack`=1 on the 6th address bit.
  - `mem_wr_en` pulses once with `mem_addr`=10'h3A3, `mem_wr_data`=8'hC6.
- Read address 16'h1402 with memory returning 8'h5A after 3 cycles: `rd_bus` delivers 0,1,0,1,1,0,1,0. `master_ready` held low for 2 cycles mid-byte keeps `rd_bus` stable.
- Address 16'h2400 (prefix 6'h09 ≠ 6'h05): `ack`=0 on the 6th address bit, state returns to `IDLE`, no memory strobes.
- `master_valid` dropped after 9 address bits → `IDLE`. A subsequent full write completes normally.
- With `SLAVE_SPLIT_EN` and a 10-cycle read latency: `split`=1 from the `RD_REQ` cycle until `mem_rd_valid`, then 0. The byte is then delivered. Without the macro, `split` stays 0.
- `rstn`=0 asserted in `RX_DATA` after 4 data bits: next cycle all outputs at reset values, and no `mem_wr_en` pulse follows.
